pot_term_encoder: RTL and testbench

Upstream stage of the two-term shift-add multiplier. It takes an operand pair (a, b) and rewrites the unsigned multiplier b as at most two power-of-two terms, b ≈ 2^b_i ± 2^b_j. It then presents a, b_i, b_j, one_term and b_sign with a valid strobe to the multiplier. It is a 2-stage registered pipeline with valid/ready flow control, so a stalled consumer back-pressures the producer without dropping operands.

---
 rtl/pot_term_encoder_pkg.sv | 28 ++
 rtl/pot_term_encoder_if.sv | 33 +++
 rtl/pot_term_encoder_lead_one_det.sv | 25 ++
 rtl/pot_term_encoder.sv | 139 +++++++++++++
 tb/tb_pot_term_encoder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pot_term_encoder_pkg.sv
// Shared widths and pipeline record types for the two-term power-of-two encoder.
// Holds the stage-1 record (a, t1, sign, r) and the encoded-term record.
package pot_pkg;

  localparam int A_N   = 16;
  localparam int B_N   = 16;
  localparam int IDX_N = 4;

  localparam logic [IDX_N-1:0] IDX_ONE = {{(IDX_N-1){1'b0}}, 1'b1};
  localparam logic [IDX_N-1:0] IDX_TOP = IDX_N'(B_N - 1);
  localparam logic [B_N-1:0]   B_ONE   = {{(B_N-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [A_N-1:0]   a;
    logic [IDX_N-1:0] t1;
    logic             sign;
    logic [B_N-1:0]   r;
  } s1_rec_t;

  typedef struct packed {
    logic [A_N-1:0]   a;
    logic [IDX_N-1:0] b_i;
    logic [IDX_N-1:0] b_j;
    logic             one_term;
    logic             b_sign;
  } enc_rec_t;

endpackage

// File: rtl/pot_term_encoder_if.sv
// Operand-in / encoded-term-out handshake bundle of the encoder.
// The encoder uses the slave modport; producer/consumer logic uses master.
interface pot_term_encoder_if
  import pot_pkg::*;
#(
  parameter int a_N = A_N,
  parameter int b_N = B_N,
  parameter int N   = IDX_N
);

  logic           in_vld;
  logic           in_rdy;
  logic [a_N-1:0] a;
  logic [b_N-1:0] b;
  logic           out_vld;
  logic           out_rdy;
  logic [a_N-1:0] a_out;
  logic [N-1:0]   b_i;
  logic [N-1:0]   b_j;
  logic           one_term;
  logic           b_sign;

  modport slave (
    input  in_vld, a, b, out_rdy,
    output in_rdy, out_vld, a_out, b_i, b_j, one_term, b_sign
  );

  modport master (
    output in_vld, a, b, out_rdy,
    input  in_rdy, out_vld, a_out, b_i, b_j, one_term, b_sign
  );

endinterface

// File: rtl/pot_term_encoder_lead_one_det.sv
// Leading-one detector: index of the most significant set bit plus a zero flag.
// An all-zero input reports index 0 with zero = 1.
module lead_one_det #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic [W-1:0] d_i,
  output logic [N-1:0] idx_o,
  output logic         zero_o
);

  // scan upward so the highest set bit wins
  always_comb begin
    idx_o = {N{1'b0}};
    for (int i = 0; i < W; i++) begin
      idx_o = d_i[i] ? N'(i) : idx_o;
    end
  end

  // flag the all-zero input
  always_comb begin
    zero_o = (d_i == {W{1'b0}});
  end

endmodule

// File: rtl/pot_term_encoder.sv
// Two-stage valid/ready pipeline rewriting b as 2^b_i +/- 2^b_j for the
// shift-add multiplier; stage 1 picks the dominant term, stage 2 the residue term.
module pot_term_encoder
  import pot_pkg::*;
(
  input logic               clk,
  input logic               rst,
  pot_term_encoder_if.slave bus
);

  logic             s1_vld_q, s1_vld_d;
  logic             s2_vld_q, s2_vld_d;
  s1_rec_t          s1_q, s1_d;
  enc_rec_t         s2_q, s2_d;

  logic             s1_load_s, s2_load_s;
  logic [IDX_N-1:0] p_s, rj_s;
  logic             b_zero_s, r_zero_s;
  logic             below_s, round_up_s;
  logic [B_N-1:0]   pow_s;
  s1_rec_t          enc1_s;
  enc_rec_t         enc2_s;

  lead_one_det #(.W(B_N), .N(IDX_N)) u_lod_b (
    .d_i    (bus.b),
    .idx_o  (p_s),
    .zero_o (b_zero_s)
  );

  lead_one_det #(.W(B_N), .N(IDX_N)) u_lod_r (
    .d_i    (s1_q.r),
    .idx_o  (rj_s),
    .zero_o (r_zero_s)
  );

  // pipeline advance: stage 2 frees when empty or drained, stage 1 follows
  always_comb begin
    s2_load_s = !s2_vld_q || bus.out_rdy;
    s1_load_s = !s1_vld_q || s2_load_s;
  end

  // round up to 2^(p+1) when the bit below the MSB is set and p+1 still fits
  always_comb begin
    pow_s = B_ONE << p_s;
    if (p_s != {IDX_N{1'b0}}) begin
      below_s = bus.b[p_s - IDX_ONE];
    end else begin
      below_s = 1'b0;
    end
    round_up_s = below_s && (p_s < IDX_TOP);
  end

  // stage-1 record: dominant term t1, direction and unsigned residue r
  always_comb begin
    enc1_s = {$bits(s1_rec_t){1'b0}};
    if (b_zero_s) begin
      enc1_s = {$bits(s1_rec_t){1'b0}};
    end else if (round_up_s) begin
      enc1_s.a    = bus.a;
      enc1_s.t1   = p_s + IDX_ONE;
      enc1_s.sign = 1'b1;
      enc1_s.r    = (pow_s << 1) - bus.b;
    end else begin
      enc1_s.a    = bus.a;
      enc1_s.t1   = p_s;
      enc1_s.sign = 1'b0;
      enc1_s.r    = bus.b - pow_s;
    end
  end

  // stage-2 record: residue truncated to its leading power of two
  always_comb begin
    enc2_s.a        = s1_q.a;
    enc2_s.b_i      = s1_q.t1;
    enc2_s.one_term = r_zero_s;
    if (r_zero_s) begin
      enc2_s.b_j    = {IDX_N{1'b0}};
      enc2_s.b_sign = 1'b0;
    end else begin
      enc2_s.b_j    = rj_s;
      enc2_s.b_sign = s1_q.sign;
    end
  end

  // next-state of both stages; data only moves on an actual transfer
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (s1_load_s) begin
      s1_vld_d = bus.in_vld;
      if (bus.in_vld) begin
        s1_d = enc1_s;
      end else begin
        s1_d = s1_q;
      end
    end else begin
      s1_vld_d = s1_vld_q;
    end
    if (s2_load_s) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d = enc2_s;
      end else begin
        s2_d = s2_q;
      end
    end else begin
      s2_vld_d = s2_vld_q;
    end
  end

  // pipeline state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= {$bits(s1_rec_t){1'b0}};
      s2_q     <= {$bits(enc_rec_t){1'b0}};
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  // outputs come straight from the stage-2 registers
  always_comb begin
    bus.in_rdy   = s1_load_s;
    bus.out_vld  = s2_vld_q;
    bus.a_out    = s2_q.a;
    bus.b_i      = s2_q.b_i;
    bus.b_j      = s2_q.b_j;
    bus.one_term = s2_q.one_term;
    bus.b_sign   = s2_q.b_sign;
  end

endmodule

// File: tb/tb_pot_term_encoder.sv
// Directed bench for pot_term_encoder: single-pair encodings, a stalled
// 8-pair stream and asynchronous reset with pairs in flight.
module tb_pot_term_encoder;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pot_term_encoder_if bus ();

  pot_term_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one isolated pair: checks 2-cycle latency and all encoded fields
  task automatic one_pair(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] ea, input logic [3:0] ei, input logic [3:0] ej,
                          input logic eone, input logic esign);
    bus.in_vld  = 1'b1;
    bus.a       = av;
    bus.b       = bv;
    bus.out_rdy = 1'b1;
    #1;
    chk({tag, "_in_rdy"}, 32'(bus.in_rdy), 32'd1);
    tick();
    bus.in_vld = 1'b0;
    chk({tag, "_vld_early"}, 32'(bus.out_vld), 32'd0);
    tick();
    chk({tag, "_vld"}, 32'(bus.out_vld), 32'd1);
    chk({tag, "_a_out"}, 32'(bus.a_out), 32'(ea));
    chk({tag, "_b_i"}, 32'(bus.b_i), 32'(ei));
    chk({tag, "_b_j"}, 32'(bus.b_j), 32'(ej));
    chk({tag, "_one"}, 32'(bus.one_term), 32'(eone));
    chk({tag, "_sign"}, 32'(bus.b_sign), 32'(esign));
    tick();
    chk({tag, "_drain"}, 32'(bus.out_vld), 32'd0);
  endtask

  logic [15:0] sa [8];
  logic [15:0] sb [8];
  logic [15:0] xa [8];
  logic [3:0]  xi [8];
  logic [3:0]  xj [8];
  logic        xo [8];
  logic        xs [8];

  initial begin
    int sent;
    int recv;
    logic acc;
    logic emit;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_vld  = 1'b0;
    bus.a       = 16'h0000;
    bus.b       = 16'h0000;
    bus.out_rdy = 1'b1;

    #2;
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    chk("rst_a_out", 32'(bus.a_out), 32'd0);
    chk("rst_b_i", 32'(bus.b_i), 32'd0);
    chk("rst_one", 32'(bus.one_term), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    one_pair("b7",    16'h0003, 16'h0007, 16'h0003, 4'd3,  4'd0,  1'b0, 1'b1);
    one_pair("b5",    16'h0011, 16'h0005, 16'h0011, 4'd2,  4'd0,  1'b0, 1'b0);
    one_pair("b11",   16'h0022, 16'h000B, 16'h0022, 4'd3,  4'd1,  1'b0, 1'b0);
    one_pair("b1",    16'h0033, 16'h0001, 16'h0033, 4'd0,  4'd0,  1'b1, 1'b0);
    one_pair("b0",    16'h1234, 16'h0000, 16'h0000, 4'd0,  4'd0,  1'b1, 1'b0);
    one_pair("bC000", 16'h0044, 16'hC000, 16'h0044, 4'd15, 4'd14, 1'b0, 1'b0);
    one_pair("bF0",   16'h0055, 16'h00F0, 16'h0055, 4'd8,  4'd4,  1'b0, 1'b1);

    // stream: 8 pairs back to back, consumer stalls in cycles 3..5
    sb = '{16'h0007, 16'h0005, 16'h000B, 16'h0001, 16'h0000, 16'hC000, 16'h0003, 16'h00F0};
    xi = '{4'd3, 4'd2, 4'd3, 4'd0, 4'd0, 4'd15, 4'd2, 4'd8};
    xj = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd14, 4'd0, 4'd4};
    xo = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    xs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      sa[k] = 16'h0100 + 16'(k);
      xa[k] = (k == 4) ? 16'h0000 : 16'h0100 + 16'(k);
    end
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      bus.out_rdy = (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1;
      bus.in_vld  = (sent < 8) ? 1'b1 : 1'b0;
      bus.a       = (sent < 8) ? sa[sent] : 16'h0000;
      bus.b       = (sent < 8) ? sb[sent] : 16'h0000;
      #1;
      if (cyc == 3) chk("stall_in_rdy", 32'(bus.in_rdy), 32'd0);
      if (cyc == 6) chk("resume_in_rdy", 32'(bus.in_rdy), 32'd1);
      acc  = bus.in_vld && bus.in_rdy;
      emit = bus.out_vld && bus.out_rdy;
      if (bus.out_vld && recv < 8) begin
        chk($sformatf("s%0d_a_out", recv), 32'(bus.a_out), 32'(xa[recv]));
        chk($sformatf("s%0d_b_i", recv), 32'(bus.b_i), 32'(xi[recv]));
        chk($sformatf("s%0d_b_j", recv), 32'(bus.b_j), 32'(xj[recv]));
        chk($sformatf("s%0d_one", recv), 32'(bus.one_term), 32'(xo[recv]));
        chk($sformatf("s%0d_sign", recv), 32'(bus.b_sign), 32'(xs[recv]));
      end
      if (emit) recv++;
      if (acc) sent++;
      tick();
    end
    bus.in_vld = 1'b0;
    chk("stream_sent", 32'(sent), 32'd8);
    chk("stream_recv", 32'(recv), 32'd8);
    chk("stream_empty", 32'(bus.out_vld), 32'd0);

    // async reset with two pairs in flight
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    bus.a       = 16'h0003;
    bus.b       = 16'h0007;
    tick();
    bus.a = 16'h0005;
    bus.b = 16'h000B;
    tick();
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    #1;
    chk("pre_rst_vld", 32'(bus.out_vld), 32'd1);
    chk("pre_rst_b_i", 32'(bus.b_i), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("arst_a_out", 32'(bus.a_out), 32'd0);
    chk("arst_b_i", 32'(bus.b_i), 32'd0);
    chk("arst_sign", 32'(bus.b_sign), 32'd0);
    chk("arst_in_rdy", 32'(bus.in_rdy), 32'd1);
    tick();
    rst = 1'b0;
    chk("post_rst_vld", 32'(bus.out_vld), 32'd0);
    one_pair("after_rst", 16'h0009, 16'h0005, 16'h0009, 4'd2, 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
